// File: rtl/dm_access_if.sv
// Pipeline/memory bundle for the MEM-stage access unit.
// The master side is the surrounding pipeline plus data memory.
interface dm_access_if;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pcadd4;
  logic        busy;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_pcadd4;
  logic [31:0] mem_rdata;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_pcadd4,
    output mem_rdata,
    input  busy, resp_valid, resp_rdata, resp_err,
    input  mem_addr, mem_wdata, mem_we, mem_pcadd4
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_pcadd4,
    input  mem_rdata,
    output busy, resp_valid, resp_rdata, resp_err,
    output mem_addr, mem_wdata, mem_we, mem_pcadd4
  );
endinterface

// File: rtl/dm_access_unit.sv
// MEM-stage load/store initiator over a word-only data memory.
// Sub-word stores are done as read-modify-write.
module dm_access_unit #(
  parameter bit MISALIGN_TRAP = 1'b1
) (
  input logic      clk,
  input logic      reset,
  dm_access_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, RD, WR, RSP
  } state_e;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LB  = 3'd1;
  localparam logic [2:0] OP_LBU = 3'd2;
  localparam logic [2:0] OP_LH  = 3'd3;
  localparam logic [2:0] OP_LHU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SB  = 3'd6;
  localparam logic [2:0] OP_SH  = 3'd7;

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        is_half, is_word, misal, trap;
  logic [31:0] ea;
  logic [4:0]  bsh, hsh;
  logic [31:0] mask, lane, merged, ld;
  logic [7:0]  rb;
  logic [15:0] rh;

  // Request classification and alignment fix-up
  always_comb begin
    is_half = (bus.req_op == OP_LH) || (bus.req_op == OP_LHU)
           || (bus.req_op == OP_SH);
    is_word = (bus.req_op == OP_LW) || (bus.req_op == OP_SW);
    misal   = (is_half && bus.req_addr[0])
           || (is_word && (bus.req_addr[1:0] != 2'b00));
    trap    = MISALIGN_TRAP && misal;
    ea      = bus.req_addr;
    if (!MISALIGN_TRAP) begin
      if (is_half) ea[0] = 1'b0;
      if (is_word) ea[1:0] = 2'b00;
    end
  end

  // Lane extraction and merge on the word read in RD
  always_comb begin
    bsh    = {addr_q[1:0], 3'b000};
    hsh    = {addr_q[1], 4'b0000};
    rb     = 8'(bus.mem_rdata >> bsh);
    rh     = 16'(bus.mem_rdata >> hsh);
    mask   = (op_q == OP_SB) ? (32'h0000_00ff << bsh)
                             : (32'h0000_ffff << hsh);
    lane   = (op_q == OP_SB) ? (wdata_q << bsh) : (wdata_q << hsh);
    merged = (bus.mem_rdata & ~mask) | (lane & mask);
    unique case (op_q)
      OP_LB:   ld = {{24{rb[7]}}, rb};
      OP_LBU:  ld = {24'h0, rb};
      OP_LH:   ld = {{16{rh[15]}}, rh};
      OP_LHU:  ld = {16'h0, rh};
      default: ld = bus.mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    pc_d    = pc_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          op_d    = bus.req_op;
          addr_d  = ea;
          wdata_d = bus.req_wdata;
          pc_d    = bus.req_pcadd4;
          rdata_d = 32'h0;
          err_d   = trap;
          if (trap)                     state_d = RSP;
          else if (bus.req_op == OP_SW) state_d = WR;
          else                          state_d = RD;
        end
      end
      RD: begin
        if (op_q == OP_SB || op_q == OP_SH) begin
          wdata_d = merged;
          state_d = WR;
        end else begin
          rdata_d = ld;
          state_d = RSP;
        end
      end
      WR:      state_d = RSP;
      RSP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= 3'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      pc_q    <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      pc_q    <= pc_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    bus.busy       = (state_q != IDLE);
    bus.resp_valid = (state_q == RSP);
    bus.resp_rdata = bus.resp_valid ? rdata_q : 32'h0;
    bus.resp_err   = bus.resp_valid && err_q;
    bus.mem_we     = (state_q == WR);
    bus.mem_wdata  = bus.mem_we ? wdata_q : 32'h0;
    bus.mem_addr   = bus.busy ? {addr_q[31:2], 2'b00} : 32'h0;
    bus.mem_pcadd4 = bus.busy ? pc_q : 32'h0;
  end
endmodule

// File: doc/dm_access_unit.md
Name: dm_access_unit

Overview:
- MEM-stage load/store initiator that sits between the pipeline and the word-wide data memory.
- The data memory has a combinational read (mem_rdata follows mem_addr in the same cycle), a registered word write on mem_we, and reset clearing.
- This block turns lw/lb/lbu/lh/lhu/sw/sb/sh requests into word-only memory transactions. Sub-word stores use read-modify-write; loads are extended.
- busy stalls the pipeline while an access is in flight.

Parameters:
- MISALIGN_TRAP, default 1: 1 = misaligned access is flagged and suppressed; 0 = low address bits are forced to natural alignment and the access proceeds.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request strobe; sampled only in IDLE
- req_op  in  3  000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu, 101 sw, 110 sb, 111 sh
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (sb uses [7:0], sh uses [15:0])
- req_pcadd4  in  32  PC+4 of the instruction; forwarded for the memory trace
- busy  out  1  high in any state other than IDLE
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores
- resp_err  out  1  misalignment flag; valid with resp_valid
- mem_addr  out  32  word address to memory, low two bits always 00
- mem_wdata  out  32  merged word to write
- mem_we  out  1  memory write enable
- mem_pcadd4  out  32  latched req_pcadd4
- mem_rdata  in  32  combinational read data from memory

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state IDLE; busy, resp_valid, resp_err, mem_we = 0; resp_rdata, mem_addr, mem_wdata, mem_pcadd4 = 0.
- Accept: in IDLE with req_valid=1, latch op, addr, wdata and pcadd4. Next state:
  - RSP if misaligned and MISALIGN_TRAP=1
  - WR for sw
  - RD otherwise
- Misaligned means: lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]≠00. With MISALIGN_TRAP=0, clear addr[0] for halfwords and addr[1:0] for words.
- RD: drive mem_addr = {addr[31:2],2'b00}, mem_we=0, and sample mem_rdata in the same cycle.
  - Loads: select the lane little-endian. Byte lane addr[1:0]=00 is bits [7:0], 11 is [31:24]. Halfword addr[1]=0 is [15:0].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw is a full word.
  - Register the result into resp_rdata, then go to RSP.
  - sb/sh: register the merged word (the addressed lane replaced by req_wdata low bits, other lanes kept), then go to WR.
- WR: mem_addr = word address, mem_wdata = merged word (sw: req_wdata), mem_we=1 for exactly this cycle. Go to RSP.
- RSP: resp_valid=1 for one cycle, resp_err as computed, mem_we=0. Go to IDLE.
  - busy is still 1 in RSP; a new request is accepted at the earliest in the following IDLE cycle.
- Latency, accept edge to resp_valid cycle:
  - lw/lb/lbu/lh/lhu: 2 cycles
  - sw: 2 cycles
  - sb/sh: 3 cycles
  - trapped misaligned: 1 cycle
- Trapped access: mem_we never asserted, resp_rdata=0, resp_err=1.
- mem_we asserts only in WR; never asserted twice per request.
- req_valid outside IDLE is ignored; latched fields are not disturbed.
- Reset mid-operation: at that edge return to IDLE and clear all outputs. A pending WR is dropped (no write). No resp_valid for the aborted request.
- mem_addr and mem_pcadd4 hold the latched values from accept through RSP; they are 0 in IDLE.

Test Plan:
- Preload word 0x10 = 0x11223344. lb addr 0x11 → resp_rdata 0x00000033 two cycles after accept; mem_we never high.
- Preload word 0x20 = 0x000080F0. lh 0x20 → 0xFFFF80F0; lhu 0x20 → 0x000080F0; lb 0x20 → 0xFFFFFFF0.
- Word 0x10 = 0x11223344, sb addr 0x12 wdata 0xFFFFFFAB → mem_we high exactly one cycle, mem_wdata 0x11AB3344, resp_valid on the 3rd cycle; a following lw 0x10 returns 0x11AB3344.
- sh 0x13 with MISALIGN_TRAP=1 → resp_valid + resp_err one cycle after accept, no mem_we, memory unchanged. With MISALIGN_TRAP=0 → a halfword write to 0x12 occurs.
- Back-to-back: req_valid held high with sw 0x4=0xDEADBEEF, then lw 0x4 → second accepted only after RSP; lw returns 0xDEADBEEF; busy pattern 1,1,0,1,1.
- sb issued, reset asserted during RD → next cycle IDLE, busy 0, no mem_we, memory word unchanged, no resp_valid.
